// File: rtl/stereo_pkg.sv
// Shared definitions for the stereo sum/difference scaler.
// Holds the default sample width, gain width and post-multiply shift,
// plus the controller state encoding.
package stereo_pkg;

    localparam int unsigned DW_DEFAULT    = 18;  // signed audio sample width
    localparam int unsigned KW_DEFAULT    = 4;   // unsigned gain width
    localparam int unsigned SHIFT_DEFAULT = 3;   // arithmetic right shift after multiply

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MUL_S = 2'd1,
        MUL_D = 2'd2,
        OUT   = 2'd3
    } state_e;

endpackage

// File: rtl/seq_shift_add_mult.sv
// Sequential shift-add multiplier: signed A (AW bits) times unsigned B
// (BW bits, zero-extended), one multiplier bit per cycle.
// Ports:
//   clock  - rising-edge clock
//   reset  - asynchronous active-low reset
//   start  - load A/B and process B[0] this cycle
//   A      - signed multiplicand, must be held stable while running
//   B      - unsigned multiplier, sampled on start only
//   R      - signed product, AW+BW+1 bits, final once done has been seen
//   done   - high in the cycle whose rising edge completes the last bit
module seq_shift_add_mult #(
    parameter int unsigned AW = 18,
    parameter int unsigned BW = 4
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    start,
    input  logic signed [AW-1:0]    A,
    input  logic        [BW-1:0]    B,
    output logic signed [AW+BW:0]   R,
    output logic                    done
);

    localparam int unsigned PW = AW + BW + 1;
    localparam int unsigned CW = $clog2(BW + 1);

    logic signed [PW-1:0] acc_q,    acc_d;
    logic signed [PW-1:0] mcand_q,  mcand_d;
    logic        [BW-1:0] mplier_q, mplier_d;
    logic        [CW-1:0] cnt_q,    cnt_d;
    logic                 active_q, active_d;
    logic signed [PW-1:0] a_ext;

    assign a_ext = {{(PW-AW){A[AW-1]}}, A};
    assign R     = acc_q;

    // The start cycle already consumes B[0], so a BW-bit multiply
    // completes on the BW-th rising edge counted from the start edge.
    always_comb begin
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        active_d = active_q;
        done     = 1'b0;
        if (start) begin
            acc_d    = B[0] ? a_ext : '0;
            mcand_d  = a_ext << 1;
            mplier_d = B >> 1;
            cnt_d    = CW'(1);
            active_d = (BW > 1);
            done     = (BW == 1);
        end else if (active_q) begin
            acc_d    = acc_q + (mplier_q[0] ? mcand_q : '0);
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + CW'(1);
            if (cnt_q == CW'(BW - 1)) begin
                active_d = 1'b0;
                done     = 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            active_q <= 1'b0;
        end else begin
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
            active_q <= active_d;
        end
    end

endmodule

// File: rtl/stereo_matrix_scaler.sv
// Stereo matrix scaler: forms S=(L+R)/2 and D=(L-R)/2, scales them by the
// unsigned gains Ks/Kd on one time-shared sequential multiplier, then
// optionally rounds, shifts right by SHIFT and saturates to DW bits.
// Ports:
//   clock, reset        - rising-edge clock, asynchronous active-low reset
//   LEFT, RIGHT         - signed input samples
//   Ks, Kd              - unsigned sum / difference gains
//   round_en            - 1: round half up, 0: floor
//   clken_48            - one-cycle sample strobe
//   LpR_out, LmR_out    - registered scaled sum / difference
//   out_valid           - one-cycle pulse on new results
//   busy                - high while multiplying
//   sat_LpR, sat_LmR    - saturation flags, valid with out_valid
//   sample_drop         - pulse when a strobe arrives while busy
module stereo_matrix_scaler
    import stereo_pkg::*;
#(
    parameter int unsigned DW    = DW_DEFAULT,
    parameter int unsigned KW    = KW_DEFAULT,
    parameter int unsigned SHIFT = SHIFT_DEFAULT
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic signed [DW-1:0] LEFT,
    input  logic signed [DW-1:0] RIGHT,
    input  logic        [KW-1:0] Ks,
    input  logic        [KW-1:0] Kd,
    input  logic                 round_en,
    input  logic                 clken_48,
    output logic signed [DW-1:0] LpR_out,
    output logic signed [DW-1:0] LmR_out,
    output logic                 out_valid,
    output logic                 busy,
    output logic                 sat_LpR,
    output logic                 sat_LmR,
    output logic                 sample_drop
);

    localparam int unsigned PW = DW + KW + 1;

    localparam logic signed [PW:0] RND_K = (PW+1)'(1) << (SHIFT - 1);
    localparam logic signed [PW:0] MAX_V = {{(PW-DW+2){1'b0}}, {(DW-1){1'b1}}};
    localparam logic signed [PW:0] MIN_V = {{(PW-DW+2){1'b1}}, {(DW-1){1'b0}}};

    state_e                state_q;
    logic signed [DW-1:0]  left_q, right_q;
    logic        [KW-1:0]  ks_q, kd_q;
    logic                  rnd_q;
    logic signed [PW-1:0]  prod_s_q;
    logic                  mstart_q;
    logic                  busy_q, out_valid_q, drop_q;
    logic signed [DW-1:0]  lpr_q, lmr_q;
    logic                  sat_lpr_q, sat_lmr_q;

    logic        [DW:0]    sum_w, dif_w;
    logic signed [DW-1:0]  s_w, d_w;
    logic signed [DW-1:0]  mul_a;
    logic        [KW-1:0]  mul_b;
    logic signed [PW-1:0]  mul_r;
    logic                  mul_done;
    logic                  accept;
    logic        [DW:0]    scaled_s, scaled_d;

    // Halving at DW+1 bits keeps the full-range sum/difference exact in DW bits.
    assign sum_w = {left_q[DW-1], left_q} + {right_q[DW-1], right_q};
    assign dif_w = {left_q[DW-1], left_q} - {right_q[DW-1], right_q};
    assign s_w   = sum_w[DW:1];
    assign d_w   = dif_w[DW:1];

    assign mul_a  = (state_q == MUL_D) ? d_w  : s_w;
    assign mul_b  = (state_q == MUL_D) ? kd_q : ks_q;
    assign accept = clken_48 && ((state_q == IDLE) || (state_q == OUT));

    seq_shift_add_mult #(
        .AW(DW),
        .BW(KW)
    ) u_mult (
        .clock (clock),
        .reset (reset),
        .start (mstart_q),
        .A     (mul_a),
        .B     (mul_b),
        .R     (mul_r),
        .done  (mul_done)
    );

    // Returns {saturated, value}: optional half-up bias, arithmetic shift, clamp.
    function automatic logic [DW:0] scale(input logic signed [PW-1:0] p, input logic rnd);
        logic signed [PW:0] x;
        logic signed [PW:0] y;
        x = $signed({p[PW-1], p}) + (rnd ? RND_K : '0);
        y = x >>> SHIFT;
        if (y > MAX_V)
            scale = {1'b1, MAX_V[DW-1:0]};
        else if (y < MIN_V)
            scale = {1'b1, MIN_V[DW-1:0]};
        else
            scale = {1'b0, y[DW-1:0]};
    endfunction

    // During OUT the multiplier still holds the D product; S was parked earlier.
    assign scaled_s = scale(prod_s_q, rnd_q);
    assign scaled_d = scale(mul_r, rnd_q);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            left_q      <= '0;
            right_q     <= '0;
            ks_q        <= '0;
            kd_q        <= '0;
            rnd_q       <= 1'b0;
            prod_s_q    <= '0;
            mstart_q    <= 1'b0;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b0;
            drop_q      <= 1'b0;
            lpr_q       <= '0;
            lmr_q       <= '0;
            sat_lpr_q   <= 1'b0;
            sat_lmr_q   <= 1'b0;
        end else begin
            out_valid_q <= 1'b0;
            drop_q      <= 1'b0;
            mstart_q    <= 1'b0;

            if (accept) begin
                left_q  <= LEFT;
                right_q <= RIGHT;
                ks_q    <= Ks;
                kd_q    <= Kd;
                rnd_q   <= round_en;
            end

            case (state_q)
                IDLE: begin
                    if (clken_48) begin
                        state_q  <= MUL_S;
                        busy_q   <= 1'b1;
                        mstart_q <= 1'b1;
                    end
                end
                MUL_S: begin
                    drop_q <= clken_48;
                    if (mul_done) begin
                        state_q  <= MUL_D;
                        mstart_q <= 1'b1;
                    end
                end
                MUL_D: begin
                    drop_q <= clken_48;
                    // The D start edge is the last edge the S product is visible.
                    if (mstart_q)
                        prod_s_q <= mul_r;
                    if (mul_done) begin
                        state_q <= OUT;
                        busy_q  <= 1'b0;
                    end
                end
                OUT: begin
                    lpr_q       <= scaled_s[DW-1:0];
                    sat_lpr_q   <= scaled_s[DW];
                    lmr_q       <= scaled_d[DW-1:0];
                    sat_lmr_q   <= scaled_d[DW];
                    out_valid_q <= 1'b1;
                    if (clken_48) begin
                        state_q  <= MUL_S;
                        busy_q   <= 1'b1;
                        mstart_q <= 1'b1;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign LpR_out     = lpr_q;
    assign LmR_out     = lmr_q;
    assign out_valid   = out_valid_q;
    assign busy        = busy_q;
    assign sat_LpR     = sat_lpr_q;
    assign sat_LmR     = sat_lmr_q;
    assign sample_drop = drop_q;

endmodule

// File: tb/tb_stereo_matrix_scaler.sv
// Directed bench for stereo_matrix_scaler (DW=18, KW=4, SHIFT=3).
// Cycle n after a strobe is the interval ending at the n-th rising edge
// after the sampling edge; outputs are sampled on the falling edge inside it.
module tb_stereo_matrix_scaler;

    localparam int KW = 4;

    int checks = 0;
    int errors = 0;

    logic               clock = 1'b0;
    logic               reset = 1'b0;
    logic signed [17:0] LEFT = '0;
    logic signed [17:0] RIGHT = '0;
    logic        [3:0]  Ks = '0;
    logic        [3:0]  Kd = '0;
    logic               round_en = 1'b0;
    logic               clken_48 = 1'b0;
    logic signed [17:0] LpR_out;
    logic signed [17:0] LmR_out;
    logic               out_valid;
    logic               busy;
    logic               sat_LpR;
    logic               sat_LmR;
    logic               sample_drop;

    always #5 clock = ~clock;

    stereo_matrix_scaler #(
        .DW(18),
        .KW(4),
        .SHIFT(3)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .LEFT        (LEFT),
        .RIGHT       (RIGHT),
        .Ks          (Ks),
        .Kd          (Kd),
        .round_en    (round_en),
        .clken_48    (clken_48),
        .LpR_out     (LpR_out),
        .LmR_out     (LmR_out),
        .out_valid   (out_valid),
        .busy        (busy),
        .sat_LpR     (sat_LpR),
        .sat_LmR     (sat_LmR),
        .sample_drop (sample_drop)
    );

    task automatic chk(input string tag, input longint obs, input longint exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_lpr"},   LpR_out,     0);
        chk({tag, "_lmr"},   LmR_out,     0);
        chk({tag, "_valid"}, out_valid,   0);
        chk({tag, "_busy"},  busy,        0);
        chk({tag, "_satl"},  sat_LpR,     0);
        chk({tag, "_satm"},  sat_LmR,     0);
        chk({tag, "_drop"},  sample_drop, 0);
    endtask

    task automatic drive(input logic signed [17:0] l, input logic signed [17:0] r,
                         input logic [3:0] ks, input logic [3:0] kd, input logic rnd);
        LEFT     = l;
        RIGHT    = r;
        Ks       = ks;
        Kd       = kd;
        round_en = rnd;
        clken_48 = 1'b1;
    endtask

    task automatic scramble();
        LEFT     = 18'($urandom);
        RIGHT    = 18'($urandom);
        Ks       = 4'($urandom);
        Kd       = 4'($urandom);
        round_en = 1'($urandom);
    endtask

    // One isolated sample: latency, pulse width, busy span, values, hold.
    task automatic do_sample(input string tag,
                             input logic signed [17:0] l, input logic signed [17:0] r,
                             input logic [3:0] ks, input logic [3:0] kd, input logic rnd,
                             input int e_lpr, input int e_lmr, input int e_sl, input int e_sm);
        int first_n = 0;
        int pulses  = 0;
        int busy_n  = 0;
        logic signed [17:0] g_lpr = '0;
        logic signed [17:0] g_lmr = '0;
        logic g_sl = 1'b0;
        logic g_sm = 1'b0;
        @(negedge clock);
        drive(l, r, ks, kd, rnd);
        @(posedge clock);
        #1;
        clken_48 = 1'b0;
        scramble();
        for (int n = 1; n <= 2*KW + 8; n++) begin
            @(negedge clock);
            if (busy) busy_n++;
            if (out_valid) begin
                pulses++;
                if (first_n == 0) begin
                    first_n = n;
                    g_lpr = LpR_out;
                    g_lmr = LmR_out;
                    g_sl  = sat_LpR;
                    g_sm  = sat_LmR;
                end
            end
        end
        chk({tag, "_lat"},    first_n, 2*KW + 2);
        chk({tag, "_pulses"}, pulses,  1);
        chk({tag, "_busy"},   busy_n,  2*KW);
        chk({tag, "_lpr"},    g_lpr,   e_lpr);
        chk({tag, "_lmr"},    g_lmr,   e_lmr);
        chk({tag, "_satl"},   g_sl,    e_sl);
        chk({tag, "_satm"},   g_sm,    e_sm);
        chk({tag, "_hold"},   LpR_out, e_lpr);
    endtask

    task automatic do_drop();
        int first_n = 0;
        int pulses  = 0;
        int drops   = 0;
        int drop_n  = 0;
        logic signed [17:0] g_lpr = '0;
        logic signed [17:0] g_lmr = '0;
        @(negedge clock);
        drive(18'sd1000, 18'sd200, 4'd8, 4'd4, 1'b0);
        @(posedge clock);
        #1;
        clken_48 = 1'b0;
        for (int n = 1; n <= 2*KW + 8; n++) begin
            @(negedge clock);
            if (sample_drop) begin
                drops++;
                drop_n = n;
            end
            if (out_valid) begin
                pulses++;
                if (first_n == 0) begin
                    first_n = n;
                    g_lpr = LpR_out;
                    g_lmr = LmR_out;
                end
            end
            if (n == 4) drive(-18'sd5, 18'sd0, 4'd3, 4'd3, 1'b1);
            if (n == 5) clken_48 = 1'b0;
        end
        chk("drop_count",  drops,   1);
        chk("drop_cycle",  drop_n,  5);
        chk("drop_pulses", pulses,  1);
        chk("drop_lat",    first_n, 2*KW + 2);
        chk("drop_lpr",    g_lpr,   600);
        chk("drop_lmr",    g_lmr,   200);
    endtask

    task automatic do_b2b();
        int n1 = 0;
        int n2 = 0;
        int pulses = 0;
        int drops  = 0;
        logic signed [17:0] l1 = '0, m1 = '0, l2 = '0, m2 = '0;
        @(negedge clock);
        drive(18'sd1000, 18'sd200, 4'd8, 4'd4, 1'b0);
        @(posedge clock);
        #1;
        clken_48 = 1'b0;
        scramble();
        for (int n = 1; n <= 4*KW + 8; n++) begin
            @(negedge clock);
            if (sample_drop) drops++;
            if (out_valid) begin
                pulses++;
                if (pulses == 1) begin
                    n1 = n; l1 = LpR_out; m1 = LmR_out;
                end else if (pulses == 2) begin
                    n2 = n; l2 = LpR_out; m2 = LmR_out;
                end
            end
            if (n == 2*KW + 1) drive(18'sd5, 18'sd0, 4'd3, 4'd3, 1'b1);
            if (n == 2*KW + 2) begin
                clken_48 = 1'b0;
                scramble();
            end
        end
        chk("b2b_pulses", pulses, 2);
        chk("b2b_drops",  drops,  0);
        chk("b2b_lat1",   n1,     10);
        chk("b2b_lat2",   n2,     19);
        chk("b2b_lpr1",   l1,     600);
        chk("b2b_lmr1",   m1,     200);
        chk("b2b_lpr2",   l2,     1);
        chk("b2b_lmr2",   m2,     1);
    endtask

    task automatic do_reset_mid();
        int pulses = 0;
        int busy_n = 0;
        @(negedge clock);
        drive(18'sd1000, 18'sd200, 4'd8, 4'd4, 1'b0);
        @(posedge clock);
        #1;
        clken_48 = 1'b0;
        repeat (6) @(negedge clock);
        chk("rstmid_busy_before", busy, 1);
        reset = 1'b0;
        #1;
        chk_zero("rstmid_now");
        clken_48 = 1'b1;
        repeat (3) @(negedge clock);
        chk_zero("rstmid_held");
        clken_48 = 1'b0;
        reset = 1'b1;
        for (int n = 1; n <= 2*KW + 6; n++) begin
            @(negedge clock);
            if (out_valid) pulses++;
            if (busy) busy_n++;
        end
        chk("rstmid_no_valid", pulses, 0);
        chk("rstmid_no_busy",  busy_n, 0);
        chk("rstmid_lpr_after", LpR_out, 0);
        do_sample("post_rst", 18'sd1000, 18'sd200, 4'd8, 4'd4, 1'b0, 600, 200, 0, 0);
    endtask

    initial begin
        // Strobe held high during reset must be ignored.
        clken_48 = 1'b1;
        repeat (3) @(negedge clock);
        chk_zero("reset");
        clken_48 = 1'b0;
        reset = 1'b1;
        repeat (2) @(negedge clock);
        chk("idle_busy", busy, 0);

        do_sample("basic",   18'sd1000,    18'sd200,    4'd8,  4'd4,  1'b0,  600,     200, 0, 0);
        do_sample("pos_trn", 18'sd5,       18'sd0,      4'd3,  4'd3,  1'b0,  0,       0,   0, 0);
        do_sample("pos_rnd", 18'sd5,       18'sd0,      4'd3,  4'd3,  1'b1,  1,       1,   0, 0);
        do_sample("neg_trn", -18'sd5,      18'sd0,      4'd3,  4'd3,  1'b0,  -2,      -2,  0, 0);
        do_sample("neg_rnd", -18'sd5,      18'sd0,      4'd3,  4'd3,  1'b1,  -1,      -1,  0, 0);
        do_sample("sat_pos", 18'sd131071,  18'sd131071, 4'd15, 4'd15, 1'b0,  131071,  0,   1, 0);
        do_sample("sat_neg", -18'sd131072, -18'sd131072, 4'd15, 4'd15, 1'b0, -131072, 0,   1, 0);
        do_sample("gain0",   18'sd1000,    -18'sd3000,  4'd0,  4'd0,  1'b1,  0,       0,   0, 0);
        do_sample("mixed",   18'sd3000,    -18'sd1000,  4'd5,  4'd7,  1'b0,  625,     1750, 0, 0);

        do_drop();
        do_b2b();
        do_reset_mid();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
